// File: rtl/mem_port_arbiter_if.sv
// Requester and memory signals of the two-master single-port memory arbiter.
// slave: arbiter view; master: requesters plus memory (environment) view.
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-port synchronous memory: data has priority,
// fetch is forced through after STARVE_MAX consecutive losses.
module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 3
) (
  input  logic                clock,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  localparam int SW = $clog2(STARVE_MAX + 2);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, state_nxt;
  logic          decide, fetch_win;
  logic          win_if, we_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic [SW-1:0] starve_cnt;

  assign decide    = (state == IDLE || state == RESP) && (bus.if_req || bus.d_req);
  assign fetch_win = bus.if_req && (!bus.d_req || starve_cnt == SW'(STARVE_MAX));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE, RESP: state_nxt = decide ? ACCESS : IDLE;
      ACCESS:     state_nxt = RESP;
      default:    state_nxt = IDLE;
    endcase
  end

  // Winner attributes are captured only at a decision, so requesters may drop
  // or change their inputs freely once the access is under way.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      win_if     <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      starve_cnt <= '0;
    end else if (decide) begin
      win_if  <= fetch_win;
      we_r    <= !fetch_win && bus.d_we;
      addr_r  <= fetch_win ? bus.if_addr : bus.d_addr;
      wdata_r <= fetch_win ? '0 : bus.d_wdata;
      if (fetch_win || !bus.if_req)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Everything but read data is decoded from state and registered attributes.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.if_gnt    = 1'b0;
    bus.d_gnt     = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.if_rdata  = '0;
    bus.d_rdata   = '0;
    case (state)
      ACCESS: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = we_r;
        bus.mem_addr  = addr_r;
        bus.mem_wdata = wdata_r;
        bus.if_gnt    = win_if;
        bus.d_gnt     = !win_if;
      end
      RESP: begin
        bus.if_rvalid = win_if;
        bus.d_rvalid  = !win_if;
        if (win_if)     bus.if_rdata = bus.mem_rdata;
        else if (!we_r) bus.d_rdata  = bus.mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous memory.
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  mem_port_arbiter_if #(.AW(8), .DW(8)) bus ();

  mem_port_arbiter #(.AW(8), .DW(8), .STARVE_MAX(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [256];

  always @(posedge clock) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  // {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we}
  logic [5:0] flags;
  assign flags = {bus.if_gnt, bus.if_rvalid, bus.d_gnt, bus.d_rvalid, bus.mem_en, bus.mem_we};

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1;
    total++;
    if (flags !== 6'b000000) begin bad++; $display("FAIL reset_flags got=%b exp=%b", flags, 6'b0); end
    total++;
    if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata} !== 32'h0) begin
      bad++; $display("FAIL reset_buses got=%h exp=0", {bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata});
    end
    tick();
    tick();
    total++;
    if (flags !== 6'b000000) begin bad++; $display("FAIL reset_hold got=%b exp=%b", flags, 6'b0); end
    reset = 1'b1;
  endtask

  task automatic test_fetch;
    bus.if_req = 1'b1; bus.if_addr = 8'h10;
    tick();
    bus.if_req = 1'b0; bus.if_addr = 8'h00;
    total++;
    if (flags !== 6'b100010 || bus.mem_addr !== 8'h10) begin
      bad++; $display("FAIL fetch_access got=%b/%h exp=100010/10", flags, bus.mem_addr);
    end
    tick();
    total++;
    if (flags !== 6'b010000 || bus.if_rdata !== 8'hA5) begin
      bad++; $display("FAIL fetch_resp got=%b/%h exp=010000/a5", flags, bus.if_rdata);
    end
    tick();
    total++;
    if (flags !== 6'b000000) begin bad++; $display("FAIL fetch_idle got=%b exp=000000", flags); end
  endtask

  task automatic test_data_write;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'h20; bus.d_wdata = 8'h3C;
    tick();
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wdata = 8'h00;
    total++;
    if (flags !== 6'b001011 || bus.mem_addr !== 8'h20 || bus.mem_wdata !== 8'h3C) begin
      bad++; $display("FAIL write_access got=%b/%h/%h exp=001011/20/3c", flags, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    total++;
    if (flags !== 6'b000100 || bus.d_rdata !== 8'h00) begin
      bad++; $display("FAIL write_resp got=%b/%h exp=000100/00", flags, bus.d_rdata);
    end
    tick();
    total++;
    if (flags !== 6'b000000) begin bad++; $display("FAIL write_idle got=%b exp=000000", flags); end
  endtask

  task automatic test_data_read;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h20;
    tick();
    bus.d_req = 1'b0;
    total++;
    if (flags !== 6'b001010 || bus.mem_addr !== 8'h20) begin
      bad++; $display("FAIL read_access got=%b/%h exp=001010/20", flags, bus.mem_addr);
    end
    tick();
    total++;
    if (flags !== 6'b000100 || bus.d_rdata !== 8'h3C || bus.if_rdata !== 8'h00) begin
      bad++; $display("FAIL read_resp got=%b/%h/%h exp=000100/3c/00", flags, bus.d_rdata, bus.if_rdata);
    end
    tick();
  endtask

  task automatic test_starve;
    logic [5:0] exp_acc, exp_rsp;
    logic [7:0] exp_addr;
    bus.if_req = 1'b1; bus.if_addr = 8'h10;
    bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h30;
    for (int i = 0; i < 8; i++) begin
      exp_acc  = (i % 4 == 3) ? 6'b100010 : 6'b001010;
      exp_rsp  = (i % 4 == 3) ? 6'b010000 : 6'b000100;
      exp_addr = (i % 4 == 3) ? 8'h10 : 8'h30;
      tick();
      total++;
      if (flags !== exp_acc || bus.mem_addr !== exp_addr) begin
        bad++; $display("FAIL starve_grant%0d got=%b/%h exp=%b/%h", i, flags, bus.mem_addr, exp_acc, exp_addr);
      end
      tick();
      total++;
      if (flags !== exp_rsp || (i % 4 == 3 ? bus.if_rdata : bus.d_rdata) !== (i % 4 == 3 ? 8'hA5 : 8'h5A)) begin
        bad++; $display("FAIL starve_resp%0d got=%b/%h/%h exp=%b", i, flags, bus.if_rdata, bus.d_rdata, exp_rsp);
      end
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    tick();
    total++;
    if (flags !== 6'b000000) begin bad++; $display("FAIL starve_idle got=%b exp=000000", flags); end
  endtask

  task automatic test_pulse;
    int gcnt, rcnt, other;
    gcnt = 0; rcnt = 0; other = 0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h30;
    tick();
    bus.d_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      gcnt  += int'(bus.d_gnt);
      rcnt  += int'(bus.d_rvalid);
      other += int'(bus.if_gnt) + int'(bus.if_rvalid);
      tick();
    end
    total++;
    if (gcnt != 1 || rcnt != 1 || other != 0) begin
      bad++; $display("FAIL pulse_req gnt=%0d rvalid=%0d if_pulses=%0d exp=1/1/0", gcnt, rcnt, other);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    bus.if_req = 1'b1; bus.if_addr = 8'h10;
    tick();
    bus.if_req = 1'b0;
    total++;
    if (flags !== 6'b100010) begin bad++; $display("FAIL rmid_access got=%b exp=100010", flags); end
    reset = 1'b0;
    #1;
    total++;
    if (flags !== 6'b000000 || bus.mem_addr !== 8'h00 || bus.if_rdata !== 8'h00) begin
      bad++; $display("FAIL rmid_async got=%b/%h/%h exp=000000/00/00", flags, bus.mem_addr, bus.if_rdata);
    end
    #2;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (flags !== 6'b000000) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL rmid_after cycles_active=%0d exp=0", seen); end
    // release with a request already present: decision on the first clock edge
    reset = 1'b0;
    tick();
    bus.if_req = 1'b1; bus.if_addr = 8'h10;
    reset = 1'b1;
    tick();
    bus.if_req = 1'b0;
    total++;
    if (flags !== 6'b100010) begin bad++; $display("FAIL first_decision got=%b exp=100010", flags); end
    tick();
    total++;
    if (flags !== 6'b010000 || bus.if_rdata !== 8'hA5) begin
      bad++; $display("FAIL first_resp got=%b/%h exp=010000/a5", flags, bus.if_rdata);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    mem[8'h30] = 8'h5A;
    bus.mem_rdata = 8'h00;
    bus.if_req = 1'b0; bus.if_addr = 8'h00;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 8'h00; bus.d_wdata = 8'h00;
    test_reset();
    test_fetch();
    test_data_write();
    test_data_read();
    test_starve();
    test_pulse();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
